// File: rtl/tug_of_war_core.sv
// Two-player tug-of-war engine. It synchronises the buttons, waits a random delay before the go cue,
// arbitrates the first press, penalises false starts, moves the rope and detects the end of the match.
module tug_of_war_core #(
    parameter int NUM_LEDS    = 7,
    parameter int DELAY_MIN   = 50000000,
    parameter int RAND_BITS   = 26,
    parameter int TIMEOUT_CYC = 100000000,
    parameter int SHOW_CYC    = 50000000,
    parameter int FLASH_CYC   = 12500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pbl,
    input  logic                pbr,
    output logic [NUM_LEDS-1:0] leds_out,
    output logic                winner_l,
    output logic                winner_r,
    output logic                false_start
);

    localparam int C       = (NUM_LEDS - 1) / 2;
    localparam int POS_W   = $clog2(NUM_LEDS);
    localparam int RB      = (RAND_BITS > 16) ? 16 : RAND_BITS;
    localparam int MAX_AB  = (SHOW_CYC > TIMEOUT_CYC) ? SHOW_CYC : TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > FLASH_CYC) ? MAX_AB : FLASH_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int DLY_MAX = DELAY_MIN + (1 << RB) - 1;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    localparam logic [POS_W-1:0]    POS_C      = POS_W'(C);
    localparam logic [POS_W-1:0]    POS_MAX    = POS_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]    SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0]    TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]    FLASH_LAST = CNT_W'(FLASH_CYC - 1);
    localparam logic [15:0]         LFSR_SEED  = 16'hACE1;
    localparam logic [NUM_LEDS-1:0] LEDS_RST   = {{(NUM_LEDS-1){1'b0}}, 1'b1} << C;

    typedef enum logic [2:0] {
        S_SHOW,
        S_WAIT,
        S_GO,
        S_MOVE,
        S_OVER
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync_l_q, sync_r_q;
    logic                ev_l_q, ev_r_q;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DLY_W-1:0]    dly_q, dly_d, dly_load;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                flash_q, flash_d;
    logic                win_l_q, win_l_d;
    logic                win_r_q, win_r_d;
    logic                fs_q, fs_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
        logic [NUM_LEDS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (p == POS_W'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (lfsr_d == '0) lfsr_d = LFSR_SEED;
    end

    assign dly_load = DLY_W'(DELAY_MIN) + DLY_W'(lfsr_q[RB-1:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        pos_d   = pos_q;
        flash_d = flash_q;
        win_l_d = win_l_q;
        win_r_d = win_r_q;
        fs_d    = 1'b0;
        case (state_q)
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    dly_d   = dly_load;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                // A press before the cue hands the step to the opponent; a simultaneous pair just re-arms the delay.
                if (ev_l_q && ev_r_q) begin
                    dly_d = dly_load;
                end else if (ev_l_q) begin
                    pos_d   = pos_q - POS_W'(1);
                    fs_d    = 1'b1;
                    state_d = S_MOVE;
                end else if (ev_r_q) begin
                    pos_d   = pos_q + POS_W'(1);
                    fs_d    = 1'b1;
                    state_d = S_MOVE;
                end else if (dly_q <= DLY_W'(1)) begin
                    state_d = S_GO;
                    cnt_d   = '0;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            S_GO: begin
                if (ev_l_q && ev_r_q) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                end else if (ev_l_q) begin
                    pos_d   = pos_q + POS_W'(1);
                    state_d = S_MOVE;
                end else if (ev_r_q) begin
                    pos_d   = pos_q - POS_W'(1);
                    state_d = S_MOVE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MOVE: begin
                cnt_d = '0;
                if (pos_q == POS_MAX) begin
                    win_l_d = 1'b1;
                    flash_d = 1'b1;
                    state_d = S_OVER;
                end else if (pos_q == '0) begin
                    win_r_d = 1'b1;
                    flash_d = 1'b1;
                    state_d = S_OVER;
                end else begin
                    state_d = S_SHOW;
                end
            end
            S_OVER: begin
                if (cnt_q == FLASH_LAST) begin
                    cnt_d   = '0;
                    flash_d = ~flash_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_SHOW;
        endcase
    end

    // LED pattern follows the state being entered; MOVE keeps whatever the previous state showed.
    always_comb begin
        leds_d = leds_q;
        case (state_d)
            S_SHOW:  leds_d = onehot(pos_d);
            S_WAIT:  leds_d = '0;
            S_GO:    leds_d = '1;
            S_MOVE:  leds_d = leds_q;
            S_OVER:  leds_d = onehot(pos_d) & {NUM_LEDS{flash_d}};
            default: leds_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_SHOW;
            sync_l_q <= '0;
            sync_r_q <= '0;
            ev_l_q   <= 1'b0;
            ev_r_q   <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            cnt_q    <= '0;
            dly_q    <= '0;
            pos_q    <= POS_C;
            flash_q  <= 1'b1;
            win_l_q  <= 1'b0;
            win_r_q  <= 1'b0;
            fs_q     <= 1'b0;
            leds_q   <= LEDS_RST;
        end else begin
            state_q  <= state_d;
            sync_l_q <= {sync_l_q[1:0], pbl};
            sync_r_q <= {sync_r_q[1:0], pbr};
            ev_l_q   <= sync_l_q[1] & ~sync_l_q[2];
            ev_r_q   <= sync_r_q[1] & ~sync_r_q[2];
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
            pos_q    <= pos_d;
            flash_q  <= flash_d;
            win_l_q  <= win_l_d;
            win_r_q  <= win_r_d;
            fs_q     <= fs_d;
            leds_q   <= leds_d;
        end
    end

    assign leds_out    = leds_q;
    assign winner_l    = win_l_q;
    assign winner_r    = win_r_q;
    assign false_start = fs_q;

endmodule

// File: tb/tb_tug_of_war_core.sv
// Bench for tug_of_war_core: directed vector table, async-reset sequence, then random presses
// compared every cycle against a countdown-based game model.
module tb_tug_of_war_core;

    localparam int NL    = 5;
    localparam int DMIN  = 4;
    localparam int RBITS = 2;
    localparam int TO    = 16;
    localparam int SHOW  = 8;
    localparam int FLASH = 2;

    localparam int OP_RST  = 0;
    localparam int OP_RUN  = 1;
    localparam int OP_SYNC = 2;

    localparam int P_SHOW = 0;
    localparam int P_WAIT = 1;
    localparam int P_GO   = 2;
    localparam int P_MOVE = 3;
    localparam int P_OVER = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pbl;
    logic          pbr;
    logic [NL-1:0] leds_out;
    logic          winner_l;
    logic          winner_r;
    logic          false_start;

    int checks   = 0;
    int failures = 0;

    tug_of_war_core #(
        .NUM_LEDS   (NL),
        .DELAY_MIN  (DMIN),
        .RAND_BITS  (RBITS),
        .TIMEOUT_CYC(TO),
        .SHOW_CYC   (SHOW),
        .FLASH_CYC  (FLASH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pbl        (pbl),
        .pbr        (pbr),
        .leds_out   (leds_out),
        .winner_l   (winner_l),
        .winner_r   (winner_r),
        .false_start(false_start)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_phase;
    int          m_left;
    int          m_pos;
    int          m_t;
    logic        m_wl, m_wr, m_fs;
    logic [NL-1:0] m_leds;
    logic [15:0] m_lfsr;
    logic [3:0]  m_hl, m_hr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic void m_reset();
        m_phase = P_SHOW;
        m_left  = SHOW;
        m_pos   = (NL - 1) / 2;
        m_t     = 0;
        m_wl    = 1'b0;
        m_wr    = 1'b0;
        m_fs    = 1'b0;
        m_lfsr  = 16'hACE1;
        m_hl    = '0;
        m_hr    = '0;
        m_leds  = NL'(1 << m_pos);
    endfunction

    function automatic void m_step(input logic pl, input logic pr);
        logic evl, evr;
        int   r;
        evl  = m_hl[2] & ~m_hl[3];
        evr  = m_hr[2] & ~m_hr[3];
        m_hl = {m_hl[2:0], pl};
        m_hr = {m_hr[2:0], pr};
        r    = int'(m_lfsr) % (1 << RBITS);
        m_fs = 1'b0;
        case (m_phase)
            P_SHOW: begin
                m_left--;
                if (m_left == 0) begin m_phase = P_WAIT; m_left = DMIN + r; end
            end
            P_WAIT: begin
                if (evl && evr) m_left = DMIN + r;
                else if (evl || evr) begin
                    m_fs = 1'b1;
                    m_pos += evr ? 1 : -1;
                    m_phase = P_MOVE;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_GO; m_left = TO; end
                end
            end
            P_GO: begin
                if (evl && evr) begin m_phase = P_SHOW; m_left = SHOW; end
                else if (evl || evr) begin
                    m_pos += evl ? 1 : -1;
                    m_phase = P_MOVE;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_SHOW; m_left = SHOW; end
                end
            end
            P_MOVE: begin
                if (m_pos == NL - 1) begin m_wl = 1'b1; m_phase = P_OVER; m_t = 0; end
                else if (m_pos == 0) begin m_wr = 1'b1; m_phase = P_OVER; m_t = 0; end
                else begin m_phase = P_SHOW; m_left = SHOW; end
            end
            default: m_t++;
        endcase
        m_lfsr = lfsr_next(m_lfsr);
        case (m_phase)
            P_SHOW:  m_leds = NL'(1 << m_pos);
            P_WAIT:  m_leds = '0;
            P_GO:    m_leds = '1;
            P_MOVE:  m_leds = m_leds;
            default: m_leds = (((m_t / FLASH) % 2) == 0) ? NL'(1 << m_pos) : '0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step(pbl, pbr);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [NL+2:0] exp);
        logic [NL+2:0] got;
        got = {leds_out, winner_l, winner_r, false_start};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got{leds,wl,wr,fs}=%b required=%b at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        int          op;
        logic        pl;
        logic        pr;
        int          n;
        logic [NL-1:0] leds;
        logic        wl;
        logic        wr;
        logic        fs;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input int op, input logic pl, input logic pr, input int n,
                                input logic [NL-1:0] leds, input logic wl, input logic wr, input logic fs);
        vec_t v;
        v.op = op; v.pl = pl; v.pr = pr; v.n = n;
        v.leds = leds; v.wl = wl; v.wr = wr; v.fs = fs;
        tv.push_back(v);
    endfunction

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst = 1'b1;
        pbl = 1'b0;
        pbr = 1'b0;

        // Reset, void round, tie, two left wins to the end of the match
        add(OP_RST,  0, 0, 0,  5'b00100, 0, 0, 0);
        add(OP_RUN,  0, 0, 7,  5'b00100, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b00000, 0, 0, 0);
        add(OP_RUN,  0, 0, 3,  5'b00000, 0, 0, 0);
        add(OP_SYNC, 0, 0, 4,  5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 15, 5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b00100, 0, 0, 0);
        add(OP_RUN,  0, 0, 7,  5'b00100, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b00000, 0, 0, 0);
        add(OP_SYNC, 0, 0, 8,  5'b11111, 0, 0, 0);
        add(OP_RUN,  1, 1, 1,  5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 2,  5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b00100, 0, 0, 0);
        add(OP_RUN,  0, 0, 7,  5'b00100, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b00000, 0, 0, 0);
        add(OP_SYNC, 0, 0, 8,  5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 2,  5'b11111, 0, 0, 0);
        add(OP_RUN,  1, 0, 1,  5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 2,  5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b01000, 0, 0, 0);
        add(OP_RUN,  0, 0, 7,  5'b01000, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b00000, 0, 0, 0);
        add(OP_SYNC, 0, 0, 8,  5'b11111, 0, 0, 0);
        add(OP_RUN,  1, 0, 1,  5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 2,  5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b11111, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b10000, 1, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b10000, 1, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b00000, 1, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b00000, 1, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b10000, 1, 0, 0);
        add(OP_RUN,  0, 1, 1,  5'b10000, 1, 0, 0);
        add(OP_RUN,  1, 0, 1,  5'b00000, 1, 0, 0);
        add(OP_RUN,  0, 0, 5,  5'b00000, 1, 0, 0);
        // False start by right from centre, then a held left button
        add(OP_RST,  0, 0, 0,  5'b00100, 0, 0, 0);
        add(OP_RUN,  0, 0, 8,  5'b00000, 0, 0, 0);
        add(OP_RUN,  0, 1, 1,  5'b00000, 0, 0, 0);
        add(OP_RUN,  0, 0, 2,  5'b00000, 0, 0, 0);
        add(OP_RUN,  0, 0, 1,  5'b00000, 0, 0, 1);
        add(OP_RUN,  0, 0, 1,  5'b01000, 0, 0, 0);
        add(OP_RUN,  1, 0, 7,  5'b01000, 0, 0, 0);
        add(OP_RUN,  1, 0, 1,  5'b00000, 0, 0, 0);
        add(OP_SYNC, 1, 0, 8,  5'b11111, 0, 0, 0);
        add(OP_RUN,  1, 0, 15, 5'b11111, 0, 0, 0);
        add(OP_RUN,  1, 0, 1,  5'b01000, 0, 0, 0);
        add(OP_RUN,  0, 0, 7,  5'b01000, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            pbl = tv[i].pl;
            pbr = tv[i].pr;
            case (tv[i].op)
                OP_RST: begin
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                end
                OP_RUN: begin
                    repeat (tv[i].n) @(negedge clk);
                end
                default: begin
                    for (int k = 0; k < tv[i].n && leds_out !== tv[i].leds; k++) @(negedge clk);
                end
            endcase
            check($sformatf("vec%0d", i), {tv[i].leds, tv[i].wl, tv[i].wr, tv[i].fs});
        end

        // Asynchronous reset while the go cue is lit
        pbl = 1'b0;
        pbr = 1'b0;
        for (int k = 0; k < 40 && leds_out !== 5'b11111; k++) @(negedge clk);
        check("go_before_rst", {5'b11111, 3'b000});
        rst = 1'b1;
        #1;
        check("async_rst", {5'b00100, 3'b000});
        @(negedge clk);
        rst = 1'b0;

        // Random presses against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            check("rand", {m_leds, m_wl, m_wr, m_fs});
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0 || (m_phase == P_OVER && m_t > 10)) rst = 1'b1;
            if ($urandom_range(0, 5) == 0) pbl = ~pbl;
            if ($urandom_range(0, 5) == 0) pbr = ~pbr;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
